// File: rtl/inst_rom_loader.sv
// inst_rom_loader: instruction memory with a byte-stream programming engine.
// Downloader bytes are packed little-endian into words and written to
// consecutive word indices from a base. The fetch port has 1-cycle latency,
// reports misaligned/out-of-range reads and returns NOP_WORD on error.
// Optional feature macro: ROM_PARITY_EN (per-word even parity, with
// par_inject_i to corrupt stored parity and par_err_o to report it).
//
// Handshakes: a byte moves when byte_valid_i && byte_ready_o at a rising
// edge; a fetch is accepted when rd_req_i && rd_ready_o at a rising edge,
// and rd_valid_o is high for exactly the following cycle. A requester that
// sees rd_ready_o low must keep rd_req_i and rd_addr_i stable.
module inst_rom_loader #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 10,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start_i,
  input  logic [ADDR_WIDTH-1:0] load_base_i,
  input  logic [DEPTH_LOG2:0]   load_len_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  load_busy_o,
  output logic                  load_done_o,
  output logic                  rd_ready_o,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_err_o,
`ifdef ROM_PARITY_EN
  input  logic                  par_inject_i,
  output logic                  par_err_o,
`endif
  output logic [1:0]            dbg_state_o
);

  localparam int B     = DATA_WIDTH / 8;
  localparam int BL    = (B > 1) ? $clog2(B) : 0;
  localparam int BCW   = (BL > 0) ? BL : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef ROM_PARITY_EN
  localparam int MW    = DATA_WIDTH + 1;
`else
  localparam int MW    = DATA_WIDTH;
`endif
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(B - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [DEPTH_LOG2:0]     rem_q, rem_d;
  logic [BCW-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic                    mem_we;
  logic [MW-1:0]           wr_word;
  logic [MW-1:0]           mem_q [DEPTH];

  logic                    rd_accept;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic [MW-1:0]           rd_word;
  logic                    addr_err;
  logic                    rd_err_d;
  logic                    rd_valid_q;
  logic                    rd_err_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;

  assign load_busy_o = (state_q == LOAD) || (state_q == WRITE);
  assign rd_ready_o  = !load_busy_o;
  assign dbg_state_o = state_q;

  // Loader state and packing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  // Loader next state: collect B bytes, write one word, repeat until rem is 0.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    byte_ready_o = 1'b0;
    load_done_o  = 1'b0;
    mem_we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start_i) begin
          // Low address bits are dropped: the base is always word aligned.
          idx_d   = DEPTH_LOG2'(load_base_i >> BL);
          rem_d   = load_len_i;
          cnt_d   = '0;
          state_d = (load_len_i == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        byte_ready_o = 1'b1;
        if (byte_valid_i) begin
          word_d[{cnt_q, 3'b000} +: 8] = byte_data_i;
          if (cnt_q == BCW'(B - 1)) begin
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        mem_we  = 1'b1;
        idx_d   = idx_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == (DEPTH_LOG2+1)'(1)) ? DONE : LOAD;
      end
      DONE: begin
        load_done_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ROM_PARITY_EN
  // Stored bit makes the whole entry even parity unless injection flips it.
  assign wr_word = {(^word_q) ^ par_inject_i, word_q};
`else
  assign wr_word = word_q;
`endif

  // Memory array; deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= wr_word;
  end

  assign rd_accept = rd_req_i && rd_ready_o;
  assign rd_idx    = DEPTH_LOG2'(rd_addr_i >> BL);
  assign rd_word   = mem_q[rd_idx];
  assign addr_err  = (|(rd_addr_i & ALIGN_MASK)) || (|(rd_addr_i >> (DEPTH_LOG2 + BL)));
`ifdef ROM_PARITY_EN
  logic par_bad;
  logic par_err_q;
  assign par_bad   = !addr_err && (^rd_word);
  assign rd_err_d  = addr_err || par_bad;
  assign par_err_o = par_err_q;
`else
  assign rd_err_d  = addr_err;
`endif

  // Fetch response: valid pulses one cycle after acceptance, data/err hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= NOP_WORD;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) begin
        rd_err_q  <= rd_err_d;
        rd_data_q <= rd_err_d ? NOP_WORD : rd_word[DATA_WIDTH-1:0];
      end
    end
  end

`ifdef ROM_PARITY_EN
  // Parity error flag pulses together with the response that carries it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= rd_accept && par_bad;
  end
`endif

  assign rd_valid_o = rd_valid_q;
  assign rd_err_o   = rd_err_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: directed scenarios plus randomized loads and
// reads checked against a word-array model of the instruction memory.
module tb_inst_rom_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start_i = 1'b0;
  logic [31:0] load_base_i = '0;
  logic [10:0] load_len_i = '0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = '0;
  logic        byte_ready_o, load_busy_o, load_done_o, rd_ready_o;
  logic        rd_req_i = 1'b0;
  logic [31:0] rd_addr_i = '0;
  logic        rd_valid_o, rd_err_o;
  logic [31:0] rd_data_o;
  logic [1:0]  dbg_state;
`ifdef ROM_PARITY_EN
  logic        par_inject_i = 1'b0;
  logic        par_err_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one entry per word, plus whether it was ever written.
  logic [31:0] model_mem   [1024];
  bit          model_known [1024];
  bit          model_bad   [1024];
  logic [7:0]  byte_q [$];
  int          written_idx [$];
  int          busy_cnt;
  int          spurious_valid;

  inst_rom_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start_i (load_start_i),
    .load_base_i  (load_base_i),
    .load_len_i   (load_len_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .load_busy_o  (load_busy_o),
    .load_done_o  (load_done_o),
    .rd_ready_o   (rd_ready_o),
    .rd_req_i     (rd_req_i),
    .rd_addr_i    (rd_addr_i),
    .rd_valid_o   (rd_valid_o),
    .rd_data_o    (rd_data_o),
    .rd_err_o     (rd_err_o),
`ifdef ROM_PARITY_EN
    .par_inject_i (par_inject_i),
    .par_err_o    (par_err_o),
`endif
    .dbg_state_o  (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic sample_neg();
    if (load_busy_o) busy_cnt++;
    if (rd_valid_o) spurious_valid++;
  endtask

  // Stream byte_q into the loader, optionally with idle gaps between bytes.
  task automatic feed_bytes(input bit gaps);
    int n;
    foreach (byte_q[i]) begin
      if (gaps) begin
        byte_valid_i = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(negedge clk); sample_neg(); end
      end
      byte_valid_i = 1'b1;
      byte_data_i  = byte_q[i];
      n = 0;
      while (!byte_ready_o && n < 50) begin @(negedge clk); sample_neg(); n++; end
      if (n >= 50) begin
        miscompares++;
        $display("FAIL byte_ready_timeout byte=%0d got ready=0 exp 1", i);
      end
      @(negedge clk); sample_neg();
    end
    byte_valid_i = 1'b0;
  endtask

  // Full load of byte_q as len words from base; with_read also issues a
  // fetch of address 0x10 in the same cycle as load_start_i.
  task automatic do_load(input logic [31:0] base, input int len, input bit gaps,
                         input bit with_read);
    int n;
    int bidx;
    logic [31:0] exp_rd;
    bidx = int'((base >> 2) & 32'h3ff);
    exp_rd = model_mem[4];
    busy_cnt = 0;
    spurious_valid = 0;
    load_start_i = 1'b1;
    load_base_i  = base;
    load_len_i   = 11'(len);
    if (with_read) begin rd_req_i = 1'b1; rd_addr_i = 32'h10; end
    @(negedge clk);
    load_start_i = 1'b0;
    if (with_read) begin
      rd_req_i = 1'b0;
      vectors++;
      if (rd_valid_o !== 1'b1 || rd_data_o !== exp_rd) begin
        miscompares++;
        $display("FAIL same_cycle_read got valid=%b data=%h exp valid=1 data=%h",
                 rd_valid_o, rd_data_o, exp_rd);
      end
    end
    vectors++;
    if (load_busy_o !== (len != 0)) begin
      miscompares++;
      $display("FAIL busy_after_start got %b exp %b", load_busy_o, len != 0);
    end
    if (load_busy_o) busy_cnt++;
    feed_bytes(gaps);
    n = 0;
    while (!load_done_o && n < 20) begin @(negedge clk); sample_neg(); n++; end
    vectors++;
    if (load_done_o !== 1'b1) begin
      miscompares++;
      $display("FAIL load_done_timeout got 0 exp 1");
    end
    vectors++;
    if (spurious_valid != 0) begin
      miscompares++;
      $display("FAIL valid_during_load got %0d pulses exp 0", spurious_valid);
    end
    if (!gaps) begin
      vectors++;
      if (busy_cnt != len * 5) begin
        miscompares++;
        $display("FAIL load_throughput got %0d busy cycles exp %0d", busy_cnt, len * 5);
      end
    end
    @(negedge clk);
    vectors++;
    if (load_done_o !== 1'b0 || load_busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL done_single_pulse got done=%b busy=%b exp 0 0", load_done_o, load_busy_o);
    end
    for (int w = 0; w < len; w++) begin
      int k;
      k = (bidx + w) % 1024;
      model_mem[k]   = {byte_q[4*w+3], byte_q[4*w+2], byte_q[4*w+1], byte_q[4*w]};
      model_known[k] = 1'b1;
`ifdef ROM_PARITY_EN
      model_bad[k]   = par_inject_i;
`endif
      written_idx.push_back(k);
    end
  endtask

  // One fetch, checked for valid timing, error flag, data and data hold.
  task automatic do_read(input logic [31:0] a);
    int n;
    int idx;
    bit exp_err, bad, known;
    logic [31:0] exp_data;
    n = 0;
    while (!rd_ready_o && n < 100) begin @(negedge clk); n++; end
    idx     = int'((a >> 2) & 32'h3ff);
    exp_err = (a % 4 != 0) || ((a / 4) >= 1024);
    known   = exp_err || model_known[idx];
    bad     = !exp_err && model_known[idx] && model_bad[idx];
    exp_data = (exp_err || bad) ? NOP : model_mem[idx];
    rd_req_i  = 1'b1;
    rd_addr_i = a;
    @(negedge clk);
    rd_req_i = 1'b0;
    vectors++;
    if (rd_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_valid addr=%h got %b exp 1", a, rd_valid_o);
    end
    if (known) begin
      vectors++;
      if (rd_err_o !== (exp_err || bad)) begin
        miscompares++;
        $display("FAIL rd_err addr=%h got %b exp %b", a, rd_err_o, exp_err || bad);
      end
      vectors++;
      if (rd_data_o !== exp_data) begin
        miscompares++;
        $display("FAIL rd_data addr=%h got %h exp %h", a, rd_data_o, exp_data);
      end
`ifdef ROM_PARITY_EN
      vectors++;
      if (par_err_o !== bad) begin
        miscompares++;
        $display("FAIL par_err addr=%h got %b exp %b", a, par_err_o, bad);
      end
`endif
    end else begin
      vectors++;
      if (rd_err_o !== 1'b0) begin
        miscompares++;
        $display("FAIL rd_err_unwritten addr=%h got %b exp 0", a, rd_err_o);
      end
    end
    @(negedge clk);
    vectors++;
    if (rd_valid_o !== 1'b0 || (known && rd_data_o !== exp_data)) begin
      miscompares++;
      $display("FAIL rd_hold addr=%h got valid=%b data=%h exp valid=0 data=%h",
               a, rd_valid_o, rd_data_o, exp_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (byte_ready_o !== 1'b0 || load_busy_o !== 1'b0 || load_done_o !== 1'b0 ||
        rd_valid_o !== 1'b0 || rd_err_o !== 1'b0 || rd_data_o !== NOP) begin
      miscompares++;
      $display("FAIL reset_values got rdy=%b busy=%b done=%b vld=%b err=%b data=%h exp 0 0 0 0 0 %h",
               byte_ready_o, load_busy_o, load_done_o, rd_valid_o, rd_err_o, rd_data_o, NOP);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_read();
    do_read(32'h0);
    do_read(32'h2);
  endtask

  task automatic test_directed_load();
    byte_q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    do_load(32'h10, 2, 1'b0, 1'b0);
    do_read(32'h10);
    do_read(32'h14);
    vectors++;
    if (model_mem[4] !== 32'h0010_0513 || model_mem[5] !== 32'h0020_0593) begin
      miscompares++;
      $display("FAIL packing_model got %h %h exp 00100513 00200593", model_mem[4], model_mem[5]);
    end
  endtask

  task automatic test_wrap();
    byte_q.delete();
    repeat (8) byte_q.push_back(8'($urandom));
    do_load(32'hFFC, 2, 1'b0, 1'b0);
    do_read(32'hFFC);
    do_read(32'h000);
    do_read(32'h1000);
  endtask

  task automatic test_zero_len();
    byte_q.delete();
    do_load(32'h300, 0, 1'b0, 1'b0);
    do_read(32'h10);
  endtask

  task automatic test_read_blocked();
    logic [31:0] w;
    byte_q.delete();
    repeat (4) byte_q.push_back(8'($urandom));
    w = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
    load_start_i = 1'b1; load_base_i = 32'h40; load_len_i = 11'd1;
    @(negedge clk);
    load_start_i = 1'b0;
    rd_req_i = 1'b1; rd_addr_i = 32'h40;
    vectors++;
    if (rd_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_ready_busy got %b exp 0", rd_ready_o);
    end
    spurious_valid = 0;
    feed_bytes(1'b1);
    while (!rd_ready_o && spurious_valid < 100) begin
      @(negedge clk);
      if (rd_valid_o) spurious_valid++;
    end
    vectors++;
    if (spurious_valid != 0) begin
      miscompares++;
      $display("FAIL valid_while_blocked got %0d pulses exp 0", spurious_valid);
    end
    @(negedge clk);
    rd_req_i = 1'b0;
    vectors++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== w) begin
      miscompares++;
      $display("FAIL held_req_served got valid=%b data=%h exp 1 %h", rd_valid_o, rd_data_o, w);
    end
    model_mem[16] = w; model_known[16] = 1'b1; model_bad[16] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_same_cycle();
    byte_q.delete();
    repeat (4) byte_q.push_back(8'($urandom));
    do_load(32'h80, 1, 1'b0, 1'b1);
    do_read(32'h80);
  endtask

  task automatic test_reset_mid_load();
    byte_q.delete();
    repeat (8) byte_q.push_back(8'($urandom));
    do_load(32'h20, 2, 1'b1, 1'b0);
    load_start_i = 1'b1; load_base_i = 32'h20; load_len_i = 11'd1;
    @(negedge clk);
    load_start_i = 1'b0;
    byte_valid_i = 1'b1; byte_data_i = 8'hAA;
    @(negedge clk);
    byte_data_i = 8'hBB;
    @(negedge clk);
    byte_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (load_busy_o !== 1'b0 || byte_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_load got busy=%b ready=%b exp 0 0", load_busy_o, byte_ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(32'h20);
    do_read(32'h24);
  endtask

`ifdef ROM_PARITY_EN
  task automatic test_parity();
    byte_q.delete();
    repeat (4) byte_q.push_back(8'($urandom));
    par_inject_i = 1'b1;
    do_load(32'h200, 1, 1'b0, 1'b0);
    par_inject_i = 1'b0;
    do_read(32'h200);
    do_load(32'h200, 1, 1'b0, 1'b0);
    do_read(32'h200);
  endtask
`endif

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int len;
      len = $urandom_range(0, 3);
      byte_q.delete();
      repeat (len * 4) byte_q.push_back(8'($urandom));
      do_load($urandom, len, 1'b1, 1'b0);
    end
    for (int r = 0; r < 24; r++) begin
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0:       a = 32'(written_idx[$urandom_range(0, written_idx.size() - 1)] * 4);
        1:       a = {20'd0, 10'($urandom), 2'b00};
        2:       a = {20'd0, 10'($urandom), 2'($urandom_range(1, 3))};
        default: a = 32'h1000 + ($urandom & 32'h7fff_effc);
      endcase
      do_read(a);
    end
  endtask

  initial begin
    foreach (model_known[i]) begin
      model_known[i] = 1'b0;
      model_bad[i]   = 1'b0;
      model_mem[i]   = '0;
    end
    test_reset();
    test_basic_read();
    test_directed_load();
    test_wrap();
    test_zero_len();
    test_read_blocked();
    test_same_cycle();
    test_reset_mid_load();
`ifdef ROM_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
